// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and load-use stall controller for the 5-stage pipeline.
// Define HAZARD_STATS_EN to build the stall/forward statistics counters.
module hazard_forward_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

  // Handshake-free block: all outputs are level signals valid in the same
  // cycle as their inputs; stall/bubble are registered-state plus comb hazard.
  logic [0:0]  state;
  logic [3:0]  cnt;
  logic        haz;
  logic        stallInt;
  logic        memHitA, memHitB, wbHitA, wbHitB;
  logic        memValid, wbValid;

  assign memValid = mem_regwrite && (mem_rd != '0);
  assign wbValid  = wb_regwrite && (wb_rd != '0);
  assign memHitA  = memValid && (mem_rd == ex_rs);
  assign memHitB  = memValid && (mem_rd == ex_rt);
  assign wbHitA   = wbValid && (wb_rd == ex_rs);
  assign wbHitB   = wbValid && (wb_rd == ex_rt);

  always_comb begin
    fwd_a = 2'b00;
    if (memHitA)     fwd_a = 2'b10;
    else if (wbHitA) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (memHitB)     fwd_b = 2'b10;
    else if (wbHitB) fwd_b = 2'b01;
  end

  assign haz = ex_memread && ex_regwrite && (ex_rd != '0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    stallInt = 1'b0;
    case (state)
      IDLE:    stallInt = haz && !flush;
      WAIT:    stallInt = !flush;
      default: stallInt = 1'b0;
    endcase
  end

  assign stall  = stallInt;
  assign bubble = stallInt;

  // The first stall cycle is spent in IDLE, so WAIT covers the remaining LOAD_STALL-1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (haz && (LOAD_STALL > 1)) begin
            state <= WAIT;
            cnt   <= STALL_INIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] fwdCnt;
  logic             fwdAny;

  assign fwdAny = (fwd_a != 2'b00) || (fwd_b != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (stallInt && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (fwdAny && (fwdCnt != '1))     fwdCnt   <= fwdCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
  assign fwd_cnt   = fwdCnt;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule
